// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, datapath width and the multiply sequencer state type.
// Used by alu_mul_sequencer; the SIGNED_MUL_EN states exist in the enum in every build.
package alu_pkg;

  localparam int ALU_W = 24;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    CALC,
    FIX_LO,
    FIX_HI,
    DONE
  } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add WIDTHxWIDTH multiplier that borrows the shared external ALU, one add per bit.
// Optional signed support (sign-magnitude pre/post negation) is enabled by SIGNED_MUL_EN.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  input  logic             Signed,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ProdHi,
  output logic [WIDTH-1:0] ProdLo,
  output logic             AluOwn,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluAInvert,
  output logic             AluBNegate,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut
);

  mulseq_state_t    r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_prod_hi, w_prod_hi_nxt;
  logic [WIDTH-1:0] r_prod_lo, w_prod_lo_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_sum;

`ifdef SIGNED_MUL_EN
  logic r_neg, w_neg_nxt;
  logic r_carry, w_carry_nxt;
`else
  logic w_unused_signed;
  assign w_unused_signed = Signed;
`endif

  assign Busy   = r_busy;
  assign AluOwn = r_busy;
  assign Done   = r_done;
  assign ProdHi = r_prod_hi;
  assign ProdLo = r_prod_lo;

  // Next-state, datapath updates and ALU operand drive.
  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_prod_hi_nxt = r_prod_hi;
    w_prod_lo_nxt = r_prod_lo;
    w_cnt_nxt     = r_cnt;
    w_sum         = '0;
    AluA          = '0;
    AluB          = '0;
    AluAInvert    = 1'b0;
    AluBNegate    = 1'b0;
    AluOp         = OP_AND;
`ifdef SIGNED_MUL_EN
    w_neg_nxt     = r_neg;
    w_carry_nxt   = r_carry;
`endif
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_mcand_nxt   = Multiplicand;
          w_prod_lo_nxt = Multiplier;
          w_prod_hi_nxt = '0;
          w_cnt_nxt     = '0;
`ifdef SIGNED_MUL_EN
          w_neg_nxt     = Signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
          w_state_nxt   = Signed ? NEG_A : CALC;
`else
          w_state_nxt   = CALC;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        AluA  = r_prod_hi;
        AluB  = r_mcand;
        AluOp = OP_ADD;
        // Carry-out becomes the new top bit so no product bit is lost in the shift.
        w_sum = r_prod_lo[0] ? {AluCarryOut, AluResult} : {1'b0, r_prod_hi};
        w_prod_hi_nxt = w_sum[WIDTH:1];
        w_prod_lo_nxt = {w_sum[0], r_prod_lo[WIDTH-1:1]};
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_MUL_EN
          w_state_nxt = r_neg ? FIX_LO : DONE;
`else
          w_state_nxt = DONE;
`endif
        end else begin
          w_state_nxt = CALC;
        end
      end
`ifdef SIGNED_MUL_EN
      NEG_A: begin
        AluB       = r_mcand;
        AluBNegate = 1'b1;
        AluOp      = OP_ADD;
        if (r_mcand[WIDTH-1]) begin
          w_mcand_nxt = AluResult;
        end else begin
          w_mcand_nxt = r_mcand;
        end
        w_state_nxt = NEG_B;
      end
      NEG_B: begin
        AluB       = r_prod_lo;
        AluBNegate = 1'b1;
        AluOp      = OP_ADD;
        if (r_prod_lo[WIDTH-1]) begin
          w_prod_lo_nxt = AluResult;
        end else begin
          w_prod_lo_nxt = r_prod_lo;
        end
        w_state_nxt = CALC;
      end
      FIX_LO: begin
        AluB          = r_prod_lo;
        AluBNegate    = 1'b1;
        AluOp         = OP_ADD;
        w_prod_lo_nxt = AluResult;
        // A zero low word means the +1 of the two's complement ripples into the high word.
        w_carry_nxt   = (r_prod_lo == '0);
        w_state_nxt   = FIX_HI;
      end
      FIX_HI: begin
        if (r_carry) begin
          AluB       = r_prod_hi;
          AluBNegate = 1'b1;
          AluOp      = OP_ADD;
        end else begin
          AluA       = r_prod_hi;
          AluAInvert = 1'b1;
          AluB       = '1;
          AluOp      = OP_AND;
        end
        w_prod_hi_nxt = AluResult;
        w_state_nxt   = DONE;
      end
`endif
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and status registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SIGNED_MUL_EN
      r_neg     <= 1'b0;
      r_carry   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_prod_hi <= w_prod_hi_nxt;
      r_prod_lo <= w_prod_lo_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
`ifdef SIGNED_MUL_EN
      r_neg     <= w_neg_nxt;
      r_carry   <= w_carry_nxt;
`endif
    end
  end

endmodule
